// File: rtl/usrt_rx_deframer.sv
// Receive deframer: checks parity/framing of strobed frames and queues them in a small FIFO.
// Define USRT_RX_ERRCNT_EN to build the saturating parity/framing/overrun error counters.
module usrt_rx_deframer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                i_Pclk,
  input  logic                i_Rst,
  input  logic [1:0]          i_Parity,
  input  logic                i_Strobe,
  input  logic [DATA_W+2:0]   i_Frame,
  output logic [DATA_W-1:0]   o_Data,
  output logic                o_ParityOK,
  output logic                o_FrameOK,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_Full,
  output logic                o_Overrun,
  output logic [CNT_W-1:0]    o_ParErrCnt,
  output logic [CNT_W-1:0]    o_FrmErrCnt,
  output logic [CNT_W-1:0]    o_OvrCnt,
  input  logic                i_ClrCnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + 2;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  logic [DATA_W-1:0] frame_data;
  logic              frame_par;
  logic              parity_ok;
  logic              frame_ok;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;

  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              overrun_q;

  assign frame_data = i_Frame[DATA_W:1];
  assign frame_par  = i_Frame[DATA_W+1];
  assign frame_ok   = ~i_Frame[0] & i_Frame[DATA_W+2];

  always_comb begin
    parity_ok = 1'b1;
    case (i_Parity)
      PAR_NONE: parity_ok = 1'b1;
      PAR_ODD:  parity_ok = ^{frame_data, frame_par};
      PAR_EVEN: parity_ok = ~(^{frame_data, frame_par});
      PAR_MARK: parity_ok = frame_par;
      default:  parity_ok = 1'b1;
    endcase
  end

  // Pointers carry one extra wrap bit: equal MSBs with equal index means empty, differing MSBs means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot on the same edge, so a full FIFO can still accept a strobe.
  assign pop  = ~empty & i_Ready;
  assign push = i_Strobe & (~full | pop);
  assign drop = i_Strobe & full & ~pop;

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      overrun_q <= drop;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {frame_data, parity_ok, frame_ok};
  end

  assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_Data     = head[EW-1:2];
  assign o_ParityOK = head[1];
  assign o_FrameOK  = head[0];
  assign o_Valid    = ~empty;
  assign o_Full     = full;
  assign o_Overrun  = overrun_q;

`ifdef USRT_RX_ERRCNT_EN
  logic [CNT_W-1:0] par_cnt;
  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] ovr_cnt;

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      par_cnt <= '0;
      frm_cnt <= '0;
      ovr_cnt <= '0;
    end else if (i_ClrCnt) begin
      par_cnt <= '0;
      frm_cnt <= '0;
      ovr_cnt <= '0;
    end else begin
      if (push && !parity_ok && (par_cnt != '1)) par_cnt <= par_cnt + CNT_W'(1);
      if (push && !frame_ok  && (frm_cnt != '1)) frm_cnt <= frm_cnt + CNT_W'(1);
      if (drop && (ovr_cnt != '1))               ovr_cnt <= ovr_cnt + CNT_W'(1);
    end
  end

  assign o_ParErrCnt = par_cnt;
  assign o_FrmErrCnt = frm_cnt;
  assign o_OvrCnt    = ovr_cnt;
`else
  logic unused_clr;
  assign unused_clr  = i_ClrCnt;
  assign o_ParErrCnt = '0;
  assign o_FrmErrCnt = '0;
  assign o_OvrCnt    = '0;
`endif

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// Randomized and directed bench for usrt_rx_deframer against a queue-based reference model.
module tb_usrt_rx_deframer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_ODD  = 2'b01;
  localparam logic [1:0] M_EVEN = 2'b10;
  localparam logic [1:0] M_MARK = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        parity;
  logic              strobe;
  logic [DATA_W+2:0] frame;
  logic [DATA_W-1:0] data;
  logic              pok, fok, valid, ready, full, overrun, clr;
  logic [CNT_W-1:0]  par_cnt, frm_cnt, ovr_cnt;

  usrt_rx_deframer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_Pclk(clk), .i_Rst(rst), .i_Parity(parity), .i_Strobe(strobe), .i_Frame(frame),
    .o_Data(data), .o_ParityOK(pok), .o_FrameOK(fok), .o_Valid(valid), .i_Ready(ready),
    .o_Full(full), .o_Overrun(overrun), .o_ParErrCnt(par_cnt), .o_FrmErrCnt(frm_cnt),
    .o_OvrCnt(ovr_cnt), .i_ClrCnt(clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {data, parity_ok, frame_ok} plus plain integer counters.
  logic [DATA_W+1:0] mq[$];
  int m_par, m_frm, m_ovr;
  logic              e_valid, e_pok, e_fok, e_full, e_ovr;
  logic [DATA_W-1:0] e_data;
  logic [CNT_W-1:0]  e_par, e_frm, e_ocnt;

  function automatic logic ref_parity(input logic [1:0] m, input logic [DATA_W-1:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    case (m)
      M_NONE:  return 1'b1;
      M_ODD:   return (ones % 2) == 1;
      M_EVEN:  return (ones % 2) == 0;
      default: return p;
    endcase
  endfunction

  function automatic logic [DATA_W+2:0] mk_frame(input logic stop, input logic p,
                                                 input logic [DATA_W-1:0] d, input logic start);
    return {stop, p, d, start};
  endfunction

  task automatic model_outputs();
    e_valid = (mq.size() > 0);
    e_full  = (mq.size() == DEPTH);
    if (mq.size() > 0) {e_data, e_pok, e_fok} = mq[0];
    else begin e_data = '0; e_pok = 1'b0; e_fok = 1'b0; end
`ifdef USRT_RX_ERRCNT_EN
    e_par = CNT_W'(m_par); e_frm = CNT_W'(m_frm); e_ocnt = CNT_W'(m_ovr);
`else
    e_par = '0; e_frm = '0; e_ocnt = '0;
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_par = 0; m_frm = 0; m_ovr = 0;
    e_ovr = 1'b0;
    model_outputs();
  endtask

  task automatic model_step();
    bit was_full, did_pop;
    logic [DATA_W-1:0] d;
    logic p_ok, f_ok;
    was_full = (mq.size() == DEPTH);
    did_pop  = (mq.size() > 0) && ready;
    e_ovr    = 1'b0;
    if (did_pop) void'(mq.pop_front());
    if (strobe) begin
      if (!was_full || did_pop) begin
        d    = frame[DATA_W:1];
        p_ok = ref_parity(parity, d, frame[DATA_W+1]);
        f_ok = (frame[0] == 1'b0) && (frame[DATA_W+2] == 1'b1);
        mq.push_back({d, p_ok, f_ok});
        if (!p_ok && m_par < CMAX) m_par++;
        if (!f_ok && m_frm < CMAX) m_frm++;
      end else begin
        e_ovr = 1'b1;
        if (m_ovr < CMAX) m_ovr++;
      end
    end
    if (clr) begin m_par = 0; m_frm = 0; m_ovr = 0; end
    model_outputs();
  endtask

  task automatic drive_cycle(input logic s, input logic [DATA_W+2:0] f, input logic [1:0] m,
                             input logic r, input logic c);
    @(negedge clk);
    strobe = s; frame = f; parity = m; ready = r; clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, '0, M_NONE, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; strobe = 1'b1; frame = 11'h40E; parity = M_ODD; ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if ({data, pok, fok} !== '0) begin bad++; $display("FAIL reset_head got=%h/%b/%b exp=0", data, pok, fok); end
    total++; if ({par_cnt, frm_cnt, ovr_cnt} !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0", par_cnt, frm_cnt, ovr_cnt); end
    @(negedge clk);
    rst = 1'b0; strobe = 1'b0;
  endtask

  task automatic test_odd_ok();
    drive_cycle(1'b1, 11'h40E, M_ODD, 1'b1, 1'b0);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL odd_valid got=%b exp=1", valid); end
    total++; if (data !== 8'h07) begin bad++; $display("FAIL odd_data got=%h exp=07", data); end
    total++; if (pok !== 1'b1 || fok !== 1'b1) begin bad++; $display("FAIL odd_flags got=%b%b exp=11", pok, fok); end
    drive_cycle(1'b0, '0, M_ODD, 1'b1, 1'b0);
    total++; if (valid !== 1'b0 || {data, pok, fok} !== '0) begin bad++; $display("FAIL empty_head got=%b %h%b%b exp=0", valid, data, pok, fok); end
  endtask

  task automatic test_parity_even();
    drive_cycle(1'b0, '0, M_EVEN, 1'b1, 1'b1);
    total++; if (par_cnt !== '0) begin bad++; $display("FAIL even_cnt0 got=%0d exp=0", par_cnt); end
    drive_cycle(1'b1, 11'h40E, M_EVEN, 1'b1, 1'b0);
    total++; if (pok !== 1'b0) begin bad++; $display("FAIL even_bad_pok got=%b exp=0", pok); end
    total++; if (par_cnt !== e_par) begin bad++; $display("FAIL even_cnt1 got=%0d exp=%0d", par_cnt, e_par); end
    drive_cycle(1'b1, 11'h60E, M_EVEN, 1'b1, 1'b0);
    total++; if (pok !== 1'b1 || data !== 8'h07) begin bad++; $display("FAIL even_ok got=%b %h exp=1 07", pok, data); end
    drain();
  endtask

  task automatic test_framing();
    drive_cycle(1'b0, '0, M_ODD, 1'b1, 1'b1);
    drive_cycle(1'b1, 11'h00E, M_ODD, 1'b1, 1'b0);
    total++; if (fok !== 1'b0 || pok !== 1'b1) begin bad++; $display("FAIL frame_flags got=%b%b exp=10", pok, fok); end
    total++; if (frm_cnt !== e_frm) begin bad++; $display("FAIL frame_cnt got=%0d exp=%0d", frm_cnt, e_frm); end
    drive_cycle(1'b1, 11'h40F, M_MARK, 1'b1, 1'b0);
    total++; if ({pok, fok} !== 2'b00) begin bad++; $display("FAIL both_err got=%b%b exp=00", pok, fok); end
    total++; if (par_cnt !== e_par || frm_cnt !== e_frm) begin bad++; $display("FAIL both_cnt got=%0d/%0d exp=%0d/%0d", par_cnt, frm_cnt, e_par, e_frm); end
    drain();
  endtask

  task automatic test_overrun_drain();
    logic [DATA_W-1:0] d [5];
    drive_cycle(1'b0, '0, M_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d[i] = DATA_W'($urandom);
      drive_cycle(1'b1, mk_frame(1'b1, 1'b0, d[i], 1'b0), M_NONE, 1'b0, 1'b0);
      if (i == 3) begin
        total++; if (full !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL fill4 got full=%b ovr=%b exp 1 0", full, overrun); end
      end
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    total++; if (ovr_cnt !== e_ocnt) begin bad++; $display("FAIL ovr_cnt got=%0d exp=%0d", ovr_cnt, e_ocnt); end
    drive_cycle(1'b0, '0, M_NONE, 1'b0, 1'b0);
    total++; if (overrun !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL ovr_one_cycle got ovr=%b full=%b exp 0 1", overrun, full); end
    for (int i = 0; i < 4; i++) begin
      total++; if (valid !== 1'b1 || data !== d[i]) begin bad++; $display("FAIL drain%0d got=%b %h exp=1 %h", i, valid, data, d[i]); end
      drive_cycle(1'b0, '0, M_NONE, 1'b1, 1'b0);
    end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL drained got=%b exp=0", valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, mk_frame(1'b1, 1'b0, DATA_W'($urandom), 1'b0), M_NONE, 1'b0, 1'b0);
    drive_cycle(1'b1, mk_frame(1'b1, 1'b1, 8'hA5, 1'b0), M_NONE, 1'b1, 1'b0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fullpop_ovr got=%b exp=0", overrun); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fullpop_full got=%b exp=1", full); end
    total++; if (data !== e_data) begin bad++; $display("FAIL fullpop_head got=%h exp=%h", data, e_data); end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, M_NONE, 1'b1, 1'b0);
    total++; if (data !== 8'hA5 || valid !== 1'b0 || mq.size() != 0) begin
      // last pop leaves the FIFO empty, so the head must read 0
      if (!(data === 8'h00 && valid === 1'b0)) begin bad++; $display("FAIL fullpop_tail got=%b %h exp=0 00", valid, data); end
    end
  endtask

  task automatic test_saturation_clear();
    drive_cycle(1'b0, '0, M_EVEN, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 11'h40E, M_EVEN, 1'b1, 1'b0);
      total++; if (par_cnt !== e_par) begin bad++; $display("FAIL sat%0d got=%0d exp=%0d", i, par_cnt, e_par); end
    end
`ifdef USRT_RX_ERRCNT_EN
    total++; if (par_cnt !== 2'd3) begin bad++; $display("FAIL sat_stick got=%0d exp=3", par_cnt); end
`endif
    drive_cycle(1'b1, 11'h40E, M_EVEN, 1'b1, 1'b1);
    total++; if (par_cnt !== '0) begin bad++; $display("FAIL clr_with_err got=%0d exp=0", par_cnt); end
    drain();
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 11'h40E, M_ODD, 1'b0, 1'b0);
    drive_cycle(1'b1, 11'h60E, M_ODD, 1'b0, 1'b0);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b exp=1", valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (valid !== 1'b0 || full !== 1'b0 || {data, pok, fok} !== '0) begin bad++; $display("FAIL async_rst got=%b %b %h exp=0 0 00", valid, full, data); end
    @(negedge clk); strobe = 1'b1; frame = 11'h40E;
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL strobe_in_rst got=%b exp=0", valid); end
    @(negedge clk); rst = 1'b0; strobe = 1'b0;
    model_reset();
    @(posedge clk); #1;
    total++; if (valid !== 1'b0 || {par_cnt, frm_cnt, ovr_cnt} !== '0) begin bad++; $display("FAIL post_rst got=%b %0d/%0d/%0d exp=0", valid, par_cnt, frm_cnt, ovr_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom % 2) == 0, (DATA_W + 3)'($urandom), 2'($urandom),
                  ($urandom % 5) < 2, ($urandom % 20) == 0);
      total++; if (valid !== e_valid) begin bad++; $display("FAIL rnd_valid@%0d got=%b exp=%b", n, valid, e_valid); end
      total++; if (data !== e_data) begin bad++; $display("FAIL rnd_data@%0d got=%h exp=%h", n, data, e_data); end
      total++; if ({pok, fok} !== {e_pok, e_fok}) begin bad++; $display("FAIL rnd_flags@%0d got=%b%b exp=%b%b", n, pok, fok, e_pok, e_fok); end
      total++; if (full !== e_full) begin bad++; $display("FAIL rnd_full@%0d got=%b exp=%b", n, full, e_full); end
      total++; if (overrun !== e_ovr) begin bad++; $display("FAIL rnd_ovr@%0d got=%b exp=%b", n, overrun, e_ovr); end
      total++; if ({par_cnt, frm_cnt, ovr_cnt} !== {e_par, e_frm, e_ocnt}) begin
        bad++; $display("FAIL rnd_cnt@%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, par_cnt, frm_cnt, ovr_cnt, e_par, e_frm, e_ocnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_odd_ok();
    test_parity_even();
    test_framing();
    test_overrun_drain();
    test_full_pop();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usrt_rx_deframer.md
USRT_RX_DEFRAMER -- requirements
Module: usrt_rx_deframer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bits per frame (5..16).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the output FIFO depth (power of 2, 2..32).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the error counter width.
REQ-004 The block SHALL have port i_Pclk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port i_Parity, input, 2 bits: parity mode, where 00 is none, 01 odd, 10 even and 11 mark.
REQ-007 The block SHALL have port i_Strobe, input, 1 bit: a one-cycle pulse meaning i_Frame holds a complete received frame.
REQ-008 The block SHALL have port i_Frame, input, DATA_W+3 bits: bit0 start, bits [DATA_W:1] data (LSB first), bit DATA_W+1 parity, bit DATA_W+2 stop.
REQ-009 The block SHALL have port o_Data, output, DATA_W bits: data at the FIFO head.
REQ-010 The block SHALL have ports o_ParityOK and o_FrameOK, outputs, 1 bit each: status flags of the FIFO head entry.
REQ-011 The block SHALL have ports o_Valid (output, 1 bit) and i_Ready (input, 1 bit): the output handshake.
REQ-012 The block SHALL have ports o_Full (output, 1 bit), meaning the FIFO holds DEPTH entries, and o_Overrun (output, 1 bit), a one-cycle pulse when a frame is dropped.
REQ-013 The block SHALL have ports o_ParErrCnt, o_FrmErrCnt and o_OvrCnt, outputs, CNT_W bits each: error counters.
REQ-014 The block SHALL have port i_ClrCnt, input, 1 bit: synchronous clear of all three counters.

Function
REQ-015 The parity check SHALL be: none gives ParityOK=1; odd requires XOR(data, parity bit)=1; even requires it to be 0; mark requires parity bit=1.
REQ-016 FrameOK SHALL be 1 only when the start bit is 0 and the stop bit is 1.
REQ-017 On i_Strobe with the FIFO not full, the block SHALL write {data, ParityOK, FrameOK} at that edge, and o_Valid SHALL assert on the following cycle (latency 1).
REQ-018 Every field of an entry SHALL be evaluated with the i_Parity value sampled on the same edge as i_Strobe.
REQ-019 A pop SHALL occur on any edge where o_Valid=1 and i_Ready=1, after which the next entry or o_Valid=0 SHALL appear.
REQ-020 On i_Strobe with the FIFO full and no pop on that edge, the frame SHALL be dropped, o_Overrun SHALL pulse for one cycle, and FIFO contents SHALL be unchanged.
REQ-021 On i_Strobe with the FIFO full and a pop on the same edge, the push SHALL be accepted and no overrun SHALL occur.
REQ-022 When the FIFO is empty, o_Data, o_ParityOK and o_FrameOK SHALL be 0.
REQ-023 The FIFO SHALL use read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full and empty SHALL be decoded from the pointer MSBs.
REQ-024 Each counter SHALL increment by 1 on an accepted frame with the corresponding error (parity, framing) or on an overrun, and SHALL saturate at all-ones.
REQ-025 When i_ClrCnt coincides with an increment, the counter SHALL be 0 after that edge.
REQ-026 Multiple error types on one frame SHALL each increment their own counter.

Reset
REQ-027 While i_Rst=1, the block SHALL immediately clear the pointers and all counters, and SHALL drive o_Valid, o_Full, o_Overrun, o_Data, o_ParityOK and o_FrameOK to 0.
REQ-028 A reset asserted mid-operation SHALL discard all buffered entries, and i_Strobe SHALL be ignored while i_Rst=1.

Configuration
REQ-029 With macro USRT_RX_ERRCNT_EN defined, the three counters and i_ClrCnt SHALL be implemented as described.
REQ-030 Without USRT_RX_ERRCNT_EN, the counter outputs SHALL be tied to 0, i_ClrCnt SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-031 With DATA_W=8, odd mode, i_Frame=11'h40E and i_Ready=1, the bench SHALL see o_Valid a cycle later with o_Data=8'h07, o_ParityOK=1 and o_FrameOK=1.
REQ-032 With even mode and i_Frame=11'h40E, the bench SHALL see o_ParityOK=0 and o_ParErrCnt go from 0 to 1; with i_Frame=11'h60E it SHALL see o_ParityOK=1.
REQ-033 With i_Frame=11'h00E (stop bit 0), the bench SHALL see o_FrameOK=0 and o_FrmErrCnt increment by 1.
REQ-034 With i_Ready=0 and 5 strobes at DEPTH=4, the bench SHALL see o_Full=1 after 4 strobes, one o_Overrun pulse, o_OvrCnt=1, and then drain the 4 entries in order.
REQ-035 With the FIFO full, i_Strobe and a pop on the same edge, the bench SHALL see no overrun and o_Full remain 1.
REQ-036 With CNT_W=2 and 5 parity errors, the bench SHALL see the counter stick at 3; with i_ClrCnt on the same edge as an error, it SHALL read 0; an async reset with 2 entries SHALL give o_Valid=0 before the next clock edge.
